// File: rtl/spmem_pkg.sv
// Shared types and constants for the scratchpad-memory request controller.
// Holds the controller state encoding and the response-queue credit rule.
package spmem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam int RSP_FIFO_DEPTH = 3;

    // A new read may be accepted only while every accepted-but-unpopped read
    // still has a guaranteed slot in the response queue.
    function automatic logic has_credit(input int fifo_count, input logic read_in_flight);
        return (fifo_count + int'(read_in_flight)) < RSP_FIFO_DEPTH;
    endfunction

endpackage

// File: rtl/spmem_rsp_fifo.sv
// Small circular response queue: simultaneous push/pop, head data held while
// not popped, head reads as zero when empty.
module spmem_rsp_fifo
    import spmem_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = RSP_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [DATAWIDTH-1:0]         pushData,
    input  logic                         pop,
    output logic [DATAWIDTH-1:0]         headData,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTRWIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int COUNTWIDTH = $clog2(DEPTH + 1);

    logic [DATAWIDTH-1:0] storage [DEPTH];
    logic [PTRWIDTH-1:0]  rdPtr;
    logic [PTRWIDTH-1:0]  wrPtr;
    logic                 doPush;
    logic                 doPop;

    function automatic logic [PTRWIDTH-1:0] ptr_next(input logic [PTRWIDTH-1:0] ptr);
        return (ptr == PTRWIDTH'(DEPTH - 1)) ? '0 : ptr + PTRWIDTH'(1);
    endfunction

    assign doPop  = pop && (count != '0);
    assign doPush = push && ((count != COUNTWIDTH'(DEPTH)) || doPop);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= ptr_next(wrPtr);
            if (doPop)  rdPtr <= ptr_next(rdPtr);
            case ({doPush, doPop})
                2'b10:   count <= count + COUNTWIDTH'(1);
                2'b01:   count <= count - COUNTWIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the data array carries no reset; validity is tracked entirely by
    // count, so clearing storage would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (doPush) storage[wrPtr] <= pushData;
    end

    assign headData = (count != '0) ? storage[rdPtr] : '0;

endmodule

// File: rtl/spmem_request_controller.sv
// Front end for a single-port synchronous RAM: zero-fills the RAM after reset,
// then serves read/write requests with in-order, credit-limited read responses.
module spmem_request_controller
    import spmem_pkg::*;
#(
    parameter int DATAWIDTH    = 8,
    parameter int DATADEPTH    = 1024,
    parameter int ADDRESSWIDTH = $clog2(DATADEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reqValid,
    output logic                    reqReady,
    input  logic                    reqWrite,
    input  logic [ADDRESSWIDTH-1:0] reqAddress,
    input  logic [DATAWIDTH-1:0]    reqData,
    output logic                    rspValid,
    input  logic                    rspReady,
    output logic [DATAWIDTH-1:0]    rspData,
    output logic                    busy,
    output logic                    memWriteEn,
    output logic [DATAWIDTH-1:0]    memDataIn,
    output logic [ADDRESSWIDTH-1:0] memAddress,
    input  logic [DATAWIDTH-1:0]    memDataOut
);

    localparam int COUNTWIDTH = $clog2(RSP_FIFO_DEPTH + 1);
    localparam logic [ADDRESSWIDTH-1:0] LAST_ADDRESS = ADDRESSWIDTH'(DATADEPTH - 1);

    state_t                  state;
    state_t                  stateNext;
    logic [ADDRESSWIDTH-1:0] clearCount;
    logic [ADDRESSWIDTH-1:0] clearCountNext;
    logic                    readInFlight;
    logic                    readInFlightNext;
    logic                    accept;
    logic [COUNTWIDTH-1:0]   fifoCount;
    logic [DATAWIDTH-1:0]    fifoHead;
    logic                    fifoPop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= CLEAR;
            clearCount   <= '0;
            readInFlight <= 1'b0;
        end else begin
            state        <= stateNext;
            clearCount   <= clearCountNext;
            readInFlight <= readInFlightNext;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a signal unassigned and infer a latch.
        stateNext        = state;
        clearCountNext   = clearCount;
        readInFlightNext = 1'b0;
        reqReady         = 1'b0;
        accept           = 1'b0;
        busy             = 1'b1;
        memWriteEn       = 1'b0;
        memDataIn        = '0;
        memAddress       = '0;

        if (!reset) begin
            unique case (state)
                CLEAR: begin
                    memWriteEn     = 1'b1;
                    memAddress     = clearCount;
                    clearCountNext = clearCount + ADDRESSWIDTH'(1);
                    if (clearCount == LAST_ADDRESS) begin
                        stateNext      = SERVE;
                        clearCountNext = '0;
                    end
                end
                SERVE: begin
                    busy             = 1'b0;
                    reqReady         = has_credit(int'(fifoCount), readInFlight);
                    accept           = reqValid && reqReady;
                    memAddress       = reqAddress;
                    memDataIn        = reqData;
                    memWriteEn       = accept && reqWrite;
                    readInFlightNext = accept && !reqWrite;
                end
                default: stateNext = CLEAR;
            endcase
        end
    end

    // Reset is sampled synchronously, so the queue may still hold entries during
    // the first reset cycle; the outputs are masked so nothing stale escapes.
    assign rspValid = !reset && (fifoCount != '0);
    assign rspData  = reset ? '0 : fifoHead;
    assign fifoPop  = rspValid && rspReady;

    spmem_rsp_fifo #(
        .DATAWIDTH (DATAWIDTH),
        .DEPTH     (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (readInFlight),
        .pushData (memDataOut),
        .pop      (fifoPop),
        .headData (fifoHead),
        .count    (fifoCount)
    );

endmodule

// File: tb/tb_spmem_request_controller.sv
// Directed bench for spmem_request_controller with a RAM model, a shadow memory
// and an in-order expected-response queue.
module tb_spmem_request_controller;

    localparam int DW = 8;
    localparam int DD = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          reqValid;
    logic          reqReady;
    logic          reqWrite;
    logic [AW-1:0] reqAddress;
    logic [DW-1:0] reqData;
    logic          rspValid;
    logic          rspReady;
    logic [DW-1:0] rspData;
    logic          busy;
    logic          memWriteEn;
    logic [DW-1:0] memDataIn;
    logic [AW-1:0] memAddress;
    logic [DW-1:0] memDataOut;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] ram [DD];
    logic [DW-1:0] shadow [DD];
    logic [DW-1:0] expq [$];
    bit            serving = 1'b0;

    always #5 clk = ~clk;

    spmem_request_controller #(
        .DATAWIDTH    (DW),
        .DATADEPTH    (DD),
        .ADDRESSWIDTH (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .reqValid   (reqValid),
        .reqReady   (reqReady),
        .reqWrite   (reqWrite),
        .reqAddress (reqAddress),
        .reqData    (reqData),
        .rspValid   (rspValid),
        .rspReady   (rspReady),
        .rspData    (rspData),
        .busy       (busy),
        .memWriteEn (memWriteEn),
        .memDataIn  (memDataIn),
        .memAddress (memAddress),
        .memDataOut (memDataOut)
    );

    // Single-port RAM, registered read, read-old-data on same-address write.
    always @(posedge clk) begin
        if (memWriteEn) ram[memAddress] <= memDataIn;
        memDataOut <= ram[memAddress];
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic rr);
        reqValid   = v;
        reqWrite   = w;
        reqAddress = a;
        reqData    = d;
        rspReady   = rr;
        #2;
    endtask

    // Scoreboard bookkeeping for the current cycle, then move to the next one.
    task automatic advance();
        logic [DW-1:0] want;
        check("req_ready", reqReady, serving && (expq.size() < 3));
        if (rspValid && rspReady) begin
            check("rsp_expected", 32'(expq.size() != 0), 1);
            if (expq.size() != 0) begin
                want = expq.pop_front();
                check("rsp_data", rspData, want);
            end
        end
        if (reqValid && reqReady) begin
            if (reqWrite) shadow[reqAddress] = reqData;
            else          expq.push_back(shadow[reqAddress]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_clear();
        for (int i = 0; i < DD; i++) begin
            drive(1'b1, 1'b0, '0, '0, 1'b1);
            check("clr_busy", busy, 1);
            check("clr_we", memWriteEn, 1);
            check("clr_addr", memAddress, i);
            check("clr_data", memDataIn, 0);
            advance();
        end
        for (int k = 0; k < DD; k++) shadow[k] = '0;
        serving = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        check("serve_busy", busy, 0);
        check("serve_ready", reqReady, 1);
        check("serve_idle_we", memWriteEn, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int got;
        int cyc;
        logic [DW-1:0] seen [3];

        reset = 1'b1;
        drive(1'b1, 1'b0, '0, '0, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, '0, '0, 1'b1);
        check("rst_busy", busy, 1);
        check("rst_ready", reqReady, 0);
        check("rst_valid", rspValid, 0);
        check("rst_data", rspData, 0);
        check("rst_we", memWriteEn, 0);
        advance();
        reset = 1'b0;
        run_clear();

        // Write then read the same address; latency two from read accept.
        drive(1'b1, 1'b1, 4'd3, 8'hA5, 1'b1);
        check("wr_we", memWriteEn, 1);
        check("wr_addr", memAddress, 3);
        check("wr_din", memDataIn, 8'hA5);
        advance();
        drive(1'b1, 1'b0, 4'd3, 8'h00, 1'b1);
        check("rd_we", memWriteEn, 0);
        check("rd_addr", memAddress, 3);
        advance();
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        check("lat1_valid", rspValid, 0);
        advance();
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        check("lat2_valid", rspValid, 1);
        check("lat2_data", rspData, 8'hA5);
        advance();
        drive(1'b1, 1'b0, 4'd4, 8'h00, 1'b1);
        advance();
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        advance();
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        check("rd4_valid", rspValid, 1);
        check("rd4_data", rspData, 8'h00);
        advance();

        // Credit limit with a stalled consumer.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, AW'(5 + i), DW'(8'h55 + 8'h11 * i), 1'b1);
            advance();
        end
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, AW'(5 + i), '0, 1'b0);
            if (reqReady) accepted++;
            advance();
        end
        check("cr_accepts", accepted, 3);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        check("cr_ready_low", reqReady, 0);
        check("cr_held_data", rspData, 8'h55);
        got = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b1);
            if (rspValid && got < 3) begin
                seen[got] = rspData;
                got++;
            end
            advance();
        end
        check("cr_rsp_count", got, 3);
        check("cr_rsp0", seen[0], 8'h55);
        check("cr_rsp1", seen[1], 8'h66);
        check("cr_rsp2", seen[2], 8'h77);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        check("cr_ready_back", reqReady, 1);

        // Back-to-back reads at full rate.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, AW'(i), DW'(8'h10 + i), 1'b1);
            advance();
        end
        for (int i = 0; i < 10; i++) begin
            drive(i < 8, 1'b0, AW'(i), '0, 1'b1);
            if (i < 8) check("b2b_ready", reqReady, 1);
            if (i >= 2) begin
                check("b2b_valid", rspValid, 1);
                check("b2b_data", rspData, DW'(8'h10 + i - 2));
            end
            advance();
        end

        // Reset with two responses queued and one read in flight.
        drive(1'b1, 1'b0, 4'd0, '0, 1'b0);
        advance();
        drive(1'b1, 1'b0, 4'd1, '0, 1'b0);
        advance();
        drive(1'b1, 1'b0, 4'd2, '0, 1'b0);
        check("pre_rst_valid", rspValid, 1);
        advance();
        reset   = 1'b1;
        serving = 1'b0;
        expq.delete();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        check("mid_rst_valid", rspValid, 0);
        check("mid_rst_data", rspData, 0);
        check("mid_rst_busy", busy, 1);
        check("mid_rst_we", memWriteEn, 0);
        advance();
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        advance();
        reset = 1'b0;
        run_clear();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b1);
            check("no_stale", rspValid, 0);
            advance();
        end

        // Mixed random traffic against the shadow memory and response queue.
        accepted = 0;
        cyc      = 0;
        while (accepted < 1000 && cyc < 20000) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, DD - 1)), DW'($urandom), 1'($urandom_range(0, 3) != 0));
            if (reqValid && reqReady) accepted++;
            advance();
            cyc++;
        end
        check("rand_accepts", accepted, 1000);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b1);
            advance();
        end
        check("drain_empty", expq.size(), 0);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        check("drain_valid", rspValid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
